ram_controller: RTL and testbench

//  Word-addressed RAM servicing the ALU's single-cycle readReq/writeReq pulses.

---
 rtl/ram_controller_pkg.sv | 25 ++
 rtl/ram_controller_ram_array.sv | 25 ++
 rtl/ram_controller.sv | 186 ++++++++++++++++++
 tb/tb_ram_controller.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_controller_pkg.sv
// rtl/ram_controller_pkg.sv - shared state encodings, request type and debug layout for ram_controller
package ram_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_e;

   localparam logic [31:0] BAD_READ_DATA = 32'hDEADBEEF;

   typedef struct packed {
      logic        wr;
      logic        oor;
      logic [15:0] waddr;
      logic [31:0] data;
   } req_t;

   // debug = {state[7:0], waitCnt[7:0], wordAddr[15:0]}
   function automatic logic [31:0] pack_debug(input state_e st, input logic [3:0] cnt,
                                              input logic [15:0] waddr);
      return {6'd0, st, 4'd0, cnt, waddr};
   endfunction

endpackage

// File: rtl/ram_controller_ram_array.sv
// rtl/ram_controller_ram_array.sv - 32-bit word array, synchronous write, asynchronous read
module ram_controller_ram_array
   import ram_controller_pkg::*;
#(
   parameter int    ADDR_WIDTH = 8,
   parameter string INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/ram_controller.sv
// rtl/ram_controller.sv - serialised word RAM controller with wait states and one pending slot
// Build option: RAM_CTRL_BOUNDS_EN enables out-of-range address detection.
module ram_controller
   import ram_controller_pkg::*;
#(
   parameter int    ADDR_WIDTH  = 8,
   parameter int    WAIT_STATES = 1,
   parameter string INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ramAddress,
   input  logic [31:0] ramOut,
   input  logic        readReq,
   input  logic        writeReq,
   output logic [31:0] ramIn,
   output logic        readAck,
   output logic        writeAck,
   output logic        busy,
   output logic        errFlag,
   output logic [31:0] debug
);

   localparam logic [3:0] WAIT_N = 4'(WAIT_STATES);

   state_e      state_q, state_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   req_t        cur_q, cur_d;
   req_t        pend_q, pend_d;
   logic        pend_valid_q, pend_valid_d;
   logic        read_ack_q, read_ack_d;
   logic        write_ack_q, write_ack_d;
   logic [31:0] ram_in_q, ram_in_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;

   logic        addr_oor;
   logic [15:0] addr_word;
   req_t        wr_req, rd_req;
   logic        start, slot_in, drop, done, mem_we;
   req_t        start_req, slot_req, acc_req;
   logic [31:0] mem_rdata;
   logic        unused_addr;

`ifdef RAM_CTRL_BOUNDS_EN
   assign addr_oor = |ramAddress[31:ADDR_WIDTH+2];
`else
   assign addr_oor = 1'b0;
`endif

   assign unused_addr = ^{ramAddress[1:0], ramAddress[31:ADDR_WIDTH+2]};
   assign addr_word   = 16'(ramAddress[ADDR_WIDTH+1:2]);
   assign wr_req      = '{1'b1, addr_oor, addr_word, ramOut};
   assign rd_req      = '{1'b0, addr_oor, addr_word, ramOut};

   // Service order at any edge: pending slot, then write, then read.
   always_comb begin
      start     = 1'b0;
      start_req = pend_q;
      slot_in   = 1'b0;
      slot_req  = wr_req;
      drop      = 1'b0;
      if (state_q == ST_IDLE) begin
         if (pend_valid_q) begin
            start = 1'b1;
            if (writeReq) begin
               slot_in = 1'b1;
               drop    = readReq;
            end else if (readReq) begin
               slot_in  = 1'b1;
               slot_req = rd_req;
            end
         end else if (writeReq) begin
            start     = 1'b1;
            start_req = wr_req;
            slot_in   = readReq;
            slot_req  = rd_req;
         end else if (readReq) begin
            start     = 1'b1;
            start_req = rd_req;
         end
      end else if (!pend_valid_q) begin
         if (writeReq) begin
            slot_in = 1'b1;
            drop    = readReq;
         end else if (readReq) begin
            slot_in  = 1'b1;
            slot_req = rd_req;
         end
      end else begin
         drop = writeReq | readReq;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      cur_d      = cur_q;
      done       = 1'b0;
      acc_req    = (state_q == ST_IDLE) ? start_req : cur_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cur_d = start_req;
               if (WAIT_N == 4'd0) begin
                  done    = 1'b1;
                  state_d = ST_ACK;
               end else begin
                  state_d    = ST_WAIT;
                  wait_cnt_d = 4'd1;
               end
            end
         end
         ST_WAIT: begin
            if (wait_cnt_q == WAIT_N) begin
               done       = 1'b1;
               state_d    = ST_ACK;
               wait_cnt_d = 4'd0;
            end else begin
               wait_cnt_d = wait_cnt_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The memory operation lands on the same edge that registers the ack.
   always_comb begin
      mem_we       = done & acc_req.wr & ~acc_req.oor & reset;
      read_ack_d   = done & ~acc_req.wr;
      write_ack_d  = done & acc_req.wr;
      ram_in_d     = ram_in_q;
      if (read_ack_d) begin
         ram_in_d = acc_req.oor ? BAD_READ_DATA : mem_rdata;
      end
      err_d        = err_q | drop | (done & acc_req.oor);
      pend_valid_d = slot_in | (pend_valid_q & (state_q != ST_IDLE));
      pend_d       = slot_in ? slot_req : pend_q;
      busy_d       = (state_d != ST_IDLE) | pend_valid_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         wait_cnt_q   <= 4'd0;
         cur_q        <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         read_ack_q   <= 1'b0;
         write_ack_q  <= 1'b0;
         ram_in_q     <= 32'd0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         cur_q        <= cur_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         read_ack_q   <= read_ack_d;
         write_ack_q  <= write_ack_d;
         ram_in_q     <= ram_in_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
      end
   end

   ram_controller_ram_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .INIT_FILE  (INIT_FILE)
   ) u_ram_array (
      .clk   (clk),
      .we    (mem_we),
      .addr  (acc_req.waddr[ADDR_WIDTH-1:0]),
      .wdata (acc_req.data),
      .rdata (mem_rdata)
   );

   assign ramIn    = ram_in_q;
   assign readAck  = read_ack_q;
   assign writeAck = write_ack_q;
   assign busy     = busy_q;
   assign errFlag  = err_q;
   assign debug    = pack_debug(state_q, wait_cnt_q, cur_q.waddr);

endmodule

// File: tb/tb_ram_controller.sv
// tb/tb_ram_controller.sv - randomized + directed bench for ram_controller at WAIT_STATES 1, 0 and 4
module tb_ram_controller;

   localparam int NI = 3;
   localparam int W0 = 1;
   localparam int W1 = 0;
   localparam int W2 = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ram_address = '0;
   logic [31:0] ram_out = '0;
   logic        read_req = 1'b0;
   logic        write_req = 1'b0;
   logic [31:0] ram_in [NI];
   logic [31:0] debug [NI];
   logic [NI-1:0] read_ack, write_ack, busy, err_flag;

   always #5 clk = ~clk;

   ram_controller #(.ADDR_WIDTH(8), .WAIT_STATES(W0), .INIT_FILE("")) u_dut_w1 (
      .clk(clk), .reset(reset), .ramAddress(ram_address), .ramOut(ram_out),
      .readReq(read_req), .writeReq(write_req), .ramIn(ram_in[0]), .readAck(read_ack[0]),
      .writeAck(write_ack[0]), .busy(busy[0]), .errFlag(err_flag[0]), .debug(debug[0]));
   ram_controller #(.ADDR_WIDTH(8), .WAIT_STATES(W1), .INIT_FILE("")) u_dut_w0 (
      .clk(clk), .reset(reset), .ramAddress(ram_address), .ramOut(ram_out),
      .readReq(read_req), .writeReq(write_req), .ramIn(ram_in[1]), .readAck(read_ack[1]),
      .writeAck(write_ack[1]), .busy(busy[1]), .errFlag(err_flag[1]), .debug(debug[1]));
   ram_controller #(.ADDR_WIDTH(8), .WAIT_STATES(W2), .INIT_FILE("")) u_dut_w4 (
      .clk(clk), .reset(reset), .ramAddress(ram_address), .ramOut(ram_out),
      .readReq(read_req), .writeReq(write_req), .ramIn(ram_in[2]), .readAck(read_ack[2]),
      .writeAck(write_ack[2]), .busy(busy[2]), .errFlag(err_flag[2]), .debug(debug[2]));

   int n_cmp = 0;
   int n_bad = 0;
   int t = 0;

   // Reference: a server that is free again two edges after each ack, plus one waiting slot.
   int          ws [NI] = '{W0, W1, W2};
   logic [31:0] m_mem [NI][256];
   int          m_free [NI];
   bit          m_pend_v [NI];
   bit          m_pend_wr [NI];
   logic [31:0] m_pend_a [NI];
   logic [31:0] m_pend_d [NI];
   bit          m_cur_v [NI];
   int          m_cur_at [NI];
   bit          m_cur_wr [NI];
   logic [31:0] m_cur_a [NI];
   logic [31:0] m_cur_d [NI];
   bit          m_rack [NI];
   bit          m_wack [NI];
   logic [31:0] m_ram_in [NI];
   bit          m_err [NI];
   logic [31:0] pre_data [16];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h (t=%0d)", tag, obs, exp, t);
      end
   endtask

   function automatic bit oor_of(input logic [31:0] a);
`ifdef RAM_CTRL_BOUNDS_EN
      return (a >> 10) != 0;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         m_free[k] = 0; m_pend_v[k] = 0; m_cur_v[k] = 0;
         m_rack[k] = 0; m_wack[k] = 0; m_ram_in[k] = '0; m_err[k] = 0;
      end
   endtask

   task automatic model_edge(input int k, input bit w, input bit r,
                             input logic [31:0] a, input logic [31:0] d);
      bit          idle;
      bit          c_wr [3];
      logic [31:0] c_a [3];
      logic [31:0] c_d [3];
      int          n;
      logic [31:0] ca;
      idle = (t >= m_free[k]);
      n = 0;
      m_rack[k] = 0;
      m_wack[k] = 0;
      if (idle && m_pend_v[k]) begin
         c_wr[n] = m_pend_wr[k]; c_a[n] = m_pend_a[k]; c_d[n] = m_pend_d[k]; n++;
         m_pend_v[k] = 0;
      end
      if (w) begin c_wr[n] = 1; c_a[n] = a; c_d[n] = d; n++; end
      if (r) begin c_wr[n] = 0; c_a[n] = a; c_d[n] = d; n++; end
      for (int i = 0; i < n; i++) begin
         if (idle && i == 0) begin
            m_cur_v[k] = 1; m_cur_wr[k] = c_wr[i]; m_cur_a[k] = c_a[i]; m_cur_d[k] = c_d[i];
            m_cur_at[k] = t + ws[k];
            m_free[k] = t + ws[k] + 2;
         end else if (!m_pend_v[k]) begin
            m_pend_v[k] = 1; m_pend_wr[k] = c_wr[i]; m_pend_a[k] = c_a[i]; m_pend_d[k] = c_d[i];
         end else begin
            m_err[k] = 1;
         end
      end
      if (m_cur_v[k] && m_cur_at[k] == t) begin
         ca = m_cur_a[k];
         if (m_cur_wr[k]) begin
            if (!oor_of(ca)) m_mem[k][(ca >> 2) % 256] = m_cur_d[k];
            m_wack[k] = 1;
         end else begin
            m_rack[k] = 1;
            m_ram_in[k] = oor_of(ca) ? 32'hDEADBEEF : m_mem[k][(ca >> 2) % 256];
         end
         if (oor_of(ca)) m_err[k] = 1;
         m_cur_v[k] = 0;
      end
   endtask

   task automatic cycle(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      write_req = w; read_req = r; ram_address = a; ram_out = d;
      @(posedge clk);
      t++;
      for (int k = 0; k < NI; k++) model_edge(k, w, r, a, d);
      #1;
      for (int k = 0; k < NI; k++) begin
         check($sformatf("readAck[%0d]", k), 32'(read_ack[k]), 32'(m_rack[k]));
         check($sformatf("writeAck[%0d]", k), 32'(write_ack[k]), 32'(m_wack[k]));
         check($sformatf("ramIn[%0d]", k), ram_in[k], m_ram_in[k]);
         check($sformatf("busy[%0d]", k), 32'(busy[k]), 32'((t < m_free[k] - 1) || m_pend_v[k]));
         check($sformatf("errFlag[%0d]", k), 32'(err_flag[k]), 32'(m_err[k]));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 32'd0, 32'd0);
   endtask

   // Asserted between edges so the asynchronous clear is observed without a clock.
   task automatic apply_reset();
      #2;
      write_req = 0; read_req = 0;
      reset = 0;
      #1;
      for (int k = 0; k < NI; k++) begin
         check($sformatf("rst_readAck[%0d]", k), 32'(read_ack[k]), 32'd0);
         check($sformatf("rst_writeAck[%0d]", k), 32'(write_ack[k]), 32'd0);
         check($sformatf("rst_ramIn[%0d]", k), ram_in[k], 32'd0);
         check($sformatf("rst_busy[%0d]", k), 32'(busy[k]), 32'd0);
         check($sformatf("rst_errFlag[%0d]", k), 32'(err_flag[k]), 32'd0);
         check($sformatf("rst_debug[%0d]", k), debug[k], 32'd0);
      end
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1;
      model_reset();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wcyc, rcyc, racks;
      logic [31:0] rdata, a, hi;
      model_reset();
      apply_reset();

      for (int i = 0; i < 16; i++) begin
         pre_data[i] = (i == 1) ? 32'hCAFEF00D : $urandom;
         cycle(1, 0, 32'(i * 4), pre_data[i]);
         idle(6);
      end

      // write then read at one wait state
      cycle(1, 0, 32'h10, 32'h12345678);
      check("t2_wack_not_yet", 32'(write_ack[0]), 32'd0);
      idle(1);
      check("t2_wack", 32'(write_ack[0]), 32'd1);
      idle(5);
      cycle(0, 1, 32'h10, 32'd0);
      check("t2_rack_not_yet", 32'(read_ack[0]), 32'd0);
      idle(1);
      check("t2_rack", 32'(read_ack[0]), 32'd1);
      check("t2_data", ram_in[0], 32'h12345678);
      idle(1);
      check("t2_rack_width", 32'(read_ack[0]), 32'd0);

      // zero wait states
      cycle(0, 1, 32'h04, 32'd0);
      check("t3_rack_w0", 32'(read_ack[1]), 32'd1);
      check("t3_data_w0", ram_in[1], 32'hCAFEF00D);
      idle(8);

      // simultaneous read and write
      cycle(1, 1, 32'h20, 32'hA5A5A5A5);
      wcyc = -1; rcyc = -1; rdata = '0;
      for (int c = 1; c <= 8; c++) begin
         idle(1);
         if (write_ack[0] && wcyc < 0) wcyc = c;
         if (read_ack[0] && rcyc < 0) begin rcyc = c; rdata = ram_in[0]; end
      end
      check("t4_wack_cycle", 32'(wcyc), 32'd1);
      check("t4_rack_cycle", 32'(rcyc), 32'd4);
      check("t4_data", rdata, 32'hA5A5A5A5);
      check("t4_err", 32'(err_flag[0]), 32'd0);
      idle(4);

      // overflow: three back-to-back requests
      cycle(0, 1, 32'h08, 32'd0);
      cycle(0, 1, 32'h0C, 32'd0);
      cycle(0, 1, 32'h14, 32'd0);
      check("t5_err_w4", 32'(err_flag[2]), 32'd1);
      check("t5_err_w1", 32'(err_flag[0]), 32'd1);
      check("t5_err_w0", 32'(err_flag[1]), 32'd0);
      racks = 0;
      for (int c = 0; c < 16; c++) begin
         idle(1);
         if (read_ack[2]) racks++;
      end
      check("t5_racks_w4", 32'(racks), 32'd2);

      // reset in the middle of a four-wait-state write
      cycle(1, 0, 32'h14, 32'h11223344);
      idle(2);
      apply_reset();
      cycle(0, 1, 32'h14, 32'd0);
      idle(6);
      check("t1_abandoned_w4", ram_in[2], pre_data[5]);
      check("t1_done_w1", ram_in[0], 32'h11223344);
      cycle(0, 1, 32'h0C, 32'd0);
      idle(6);
      check("t1_prior_w4", ram_in[2], pre_data[3]);

      // upper address bits
      cycle(0, 1, 32'h400, 32'd0);
      idle(6);
`ifdef RAM_CTRL_BOUNDS_EN
      check("t6_data", ram_in[0], 32'hDEADBEEF);
      check("t6_err", 32'(err_flag[0]), 32'd1);
`else
      check("t6_data", ram_in[0], pre_data[0]);
      check("t6_err", 32'(err_flag[0]), 32'd0);
`endif

      for (int i = 0; i < 500; i++) begin
         hi = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
         a = {hi[21:0], 4'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, a, $urandom);
      end
      idle(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
